// File: rtl/router_pkg.sv
// Shared types for the router ingress serializer: FSM states, byte width and FIFO entry layout.
package router_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT_GNT,
    PAYLOAD,
    GAP
  } ser_state_e;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } ser_entry_t;

endpackage

// File: rtl/router_ser_fifo.sv
// Synchronous FIFO with count-based full/empty; head entry is presented combinationally.
module router_ser_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0] DepthCnt = Depth[PtrW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; only valid entries are ever read out.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/router_ingress_serializer.sv
// Byte-stream to serial lane feeder: dst bits, wait for grant, then payload LSB-first.
// Optional statistics counters are enabled by defining ROUTER_SER_STATS_EN.
module router_ingress_serializer
  import router_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DST_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
  input  logic [DST_W-1:0]  s_dst,
  input  logic              i_gnt,
  output logic              o_frame,
  output logic              o_valid,
  output logic              o_data,
  output logic              o_busy
`ifdef ROUTER_SER_STATS_EN
  ,
  output logic [15:0]       pkt_cnt,
  output logic [15:0]       byte_cnt,
  output logic [15:0]       underrun_cnt
`endif
);

  localparam int unsigned     CntW     = ($clog2(DST_W) > 3) ? $clog2(DST_W) : 3;
  localparam logic [CntW-1:0] AddrLast = CntW'(DST_W - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(BYTE_W - 1);

  logic                          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [$bits(ser_entry_t)-1:0] fifo_rdata;
  ser_entry_t                    fifo_wentry, fifo_head;

  assign fifo_wentry = '{last: s_last, data: s_data};
  assign fifo_head   = ser_entry_t'(fifo_rdata);

  router_ser_fifo #(
    .Depth(FIFO_DEPTH),
    .Width($bits(ser_entry_t))
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (fifo_push),
    .wdata_i(fifo_wentry),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Two-entry destination queue lets the next packet's dst land while the current one drains.
  logic [DST_W-1:0] dq_mem_q [2];
  logic             dq_wr_q, dq_rd_q;
  logic [1:0]       dq_cnt_q;
  logic             first_q, dq_push, dq_pop, dq_full, dq_empty;
  logic [DST_W-1:0] dq_head;

  ser_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DST_W-1:0]  addr_q, addr_d;
  logic [BYTE_W-1:0] sh_q, sh_d;
  logic              last_q, last_d, have_q, have_d;
  logic              frame_d, valid_d, data_d, take;

  assign dq_full   = (dq_cnt_q == 2'd2);
  assign dq_empty  = (dq_cnt_q == 2'd0);
  assign s_ready   = ~fifo_full & ~(first_q & dq_full);
  assign fifo_push = s_valid & s_ready;
  assign dq_push   = fifo_push & first_q;
  assign dq_pop    = (state_q == GAP);
  assign dq_head   = dq_mem_q[dq_rd_q];
  assign fifo_pop  = take;

  always_ff @(posedge clk) begin
    if (reset) begin
      first_q  <= 1'b1;
      dq_wr_q  <= 1'b0;
      dq_rd_q  <= 1'b0;
      dq_cnt_q <= 2'd0;
    end else begin
      if (fifo_push) first_q <= s_last;
      if (dq_push) begin
        dq_mem_q[dq_wr_q] <= s_dst;
        dq_wr_q           <= ~dq_wr_q;
      end
      if (dq_pop) dq_rd_q <= ~dq_rd_q;
      case ({dq_push, dq_pop})
        2'b10:   dq_cnt_q <= dq_cnt_q + 2'd1;
        2'b01:   dq_cnt_q <= dq_cnt_q - 2'd1;
        default: dq_cnt_q <= dq_cnt_q;
      endcase
    end
  end

  // Outputs are computed for the state being entered and registered alongside it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    last_d  = last_q;
    have_d  = have_q;
    frame_d = 1'b0;
    valid_d = 1'b0;
    data_d  = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !dq_empty) begin
          state_d = ADDR;
          cnt_d   = '0;
          addr_d  = dq_head;
          frame_d = 1'b1;
          data_d  = dq_head[0];
        end
      end
      ADDR: begin
        frame_d = 1'b1;
        if (cnt_q == AddrLast) begin
          state_d = WAIT_GNT;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q >> 1;
          data_d = addr_d[0];
        end
      end
      WAIT_GNT: begin
        frame_d = 1'b1;
        if (i_gnt) begin
          state_d = PAYLOAD;
          have_d  = 1'b0;
          take    = ~fifo_empty;
        end
      end
      PAYLOAD: begin
        frame_d = 1'b1;
        if (have_q && cnt_q != BitLast) begin
          cnt_d   = cnt_q + 1'b1;
          sh_d    = sh_q >> 1;
          valid_d = 1'b1;
          data_d  = sh_d[0];
        end else if (have_q && last_q) begin
          state_d = GAP;
          frame_d = 1'b0;
          have_d  = 1'b0;
        end else if (!fifo_empty) begin
          take = 1'b1;
        end else begin
          // Underrun: hold the frame open with a bubble until data arrives.
          have_d = 1'b0;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (take) begin
      sh_d    = fifo_head.data;
      last_d  = fifo_head.last;
      cnt_d   = '0;
      have_d  = 1'b1;
      valid_d = 1'b1;
      data_d  = fifo_head.data[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      have_q  <= 1'b0;
      o_frame <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      have_q  <= have_d;
      o_frame <= frame_d;
      o_valid <= valid_d;
      o_data  <= data_d;
      o_busy  <= (state_d != IDLE);
    end
  end

`ifdef ROUTER_SER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt      <= '0;
      byte_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      if (state_d == GAP && state_q != GAP) pkt_cnt <= pkt_cnt + 16'd1;
      if (take) byte_cnt <= byte_cnt + 16'd1;
      if (state_d == PAYLOAD && !have_d) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule
